// File: rtl/psum_xchg_rx_pkg.sv
// ----------------------------------------------------------------------------
// psum_xchg_pkg
// Shared definitions for the receive end of the inter-core partial-sum
// exchange: default geometry, receive FSM states and a pointer-width helper.
// ----------------------------------------------------------------------------
package psum_xchg_pkg;

   localparam int BW_DEF          = 8;
   localparam int BW_PSUM_DEF     = 2 * BW_DEF + 4;
   localparam int COL_DEF         = 8;
   localparam int TOTAL_CYCLE_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no complete frame buffered
      HOLD  = 2'd1,   // complete frame at head, fifo_in_ready asserted
      DRAIN = 2'd2    // frame partially consumed by the local core
   } rx_state_e;

   // Bits needed to index 'n' entries (at least one bit).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psum_xchg_rx_if.sv
// ----------------------------------------------------------------------------
// psum_xchg_rx_if
// Bundles the peer stream, the local drain handshake and the status flags of
// psum_xchg_rx.
//   master : the side driving peer_vld/peer_data/norm_rd (peer core + local
//            controller), observing sum_in and the flags
//   slave  : psum_xchg_rx itself
// ----------------------------------------------------------------------------
interface psum_xchg_rx_if #(
   parameter int bw_psum = psum_xchg_pkg::BW_PSUM_DEF,
   parameter int col     = psum_xchg_pkg::COL_DEF
) ();

   logic                     peer_vld;       // peer fifo_ext_rd, one word/cycle
   logic [bw_psum*col-1:0]   peer_data;      // peer sum_out
   logic                     norm_rd;        // local div, one pop/cycle
   logic [bw_psum*col-1:0]   sum_in;         // show-ahead head word, 0 if empty
   logic                     fifo_in_ready;  // complete frame at head
   logic                     ovf;            // sticky push-while-full
   logic                     udf;            // sticky pop-while-empty

   modport master (
      output peer_vld, peer_data, norm_rd,
      input  sum_in, fifo_in_ready, ovf, udf
   );

   modport slave (
      input  peer_vld, peer_data, norm_rd,
      output sum_in, fifo_in_ready, ovf, udf
   );

endinterface

// File: rtl/psum_xchg_rx_fifo.sv
// ----------------------------------------------------------------------------
// psum_ring_fifo
// Ring buffer with show-ahead read, occupancy count and sticky error flags.
//   clk, reset  : clock, synchronous active-high reset
//   push_i/din_i: write request and data (dropped when full)
//   pop_i       : read request (ignored when empty)
//   dout_o      : head word, 0 when empty
//   push_ok_o   : write accepted this cycle
//   pop_ok_o    : read accepted this cycle
//   ovf_o/udf_o : sticky overflow / underflow
// ----------------------------------------------------------------------------
module psum_ring_fifo #(
   parameter int width = 160,
   parameter int depth = 16   // power of two so pointers wrap naturally
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [width-1:0] din_i,
   input  logic             pop_i,
   output logic [width-1:0] dout_o,
   output logic             push_ok_o,
   output logic             pop_ok_o,
   output logic             ovf_o,
   output logic             udf_o
);
   import psum_xchg_pkg::*;

   localparam int PTR_W = ptr_width(depth);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;

   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             full, empty;
   logic [width-1:0] mem_q [depth];

   assign full      = (count_q == CNT_W'(depth));
   assign empty     = (count_q == '0);
   assign push_ok_o = push_i && !full;
   assign pop_ok_o  = pop_i && !empty;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (push_i && full);
      udf_d    = udf_q | (pop_i && empty);
      if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok_o)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok_o, pop_ok_o})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;   // idle or simultaneous push+pop
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // NOTE: storage is not reset; count_q gates every read, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push_ok_o) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o = empty ? '0 : mem_q[rd_ptr_q];
   assign ovf_o  = ovf_q;
   assign udf_o  = udf_q;

endmodule

// File: rtl/psum_xchg_rx.sv
// ----------------------------------------------------------------------------
// psum_xchg_rx
// Receive end of the inter-core partial-sum exchange. Buffers frames of
// total_cycle words streamed by the peer core, announces a complete frame to
// the local controller with fifo_in_ready, and drains it into the local
// core's sum_in one word per norm_rd cycle.
//   clk   : single clock
//   reset : synchronous active-high reset
//   bus   : psum_xchg_rx_if.slave (peer stream, drain handshake, flags)
// depth must equal 2*total_cycle and be a power of two.
// ----------------------------------------------------------------------------
module psum_xchg_rx #(
   parameter int bw          = psum_xchg_pkg::BW_DEF,
   parameter int bw_psum     = 2 * bw + 4,
   parameter int col         = psum_xchg_pkg::COL_DEF,
   parameter int total_cycle = psum_xchg_pkg::TOTAL_CYCLE_DEF,
   parameter int depth       = 2 * total_cycle
) (
   input logic           clk,
   input logic           reset,
   psum_xchg_rx_if.slave bus
);
   import psum_xchg_pkg::*;

   localparam int CW = ptr_width(total_cycle);
   localparam logic [CW-1:0] LAST = CW'(total_cycle - 1);

   logic          push_ok, pop_ok;
   logic          wr_wrap, rd_wrap;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [1:0]    frames_q, frames_d;   // complete frames buffered, 0..2
   rx_state_e     state_q;
   logic          ready_q;

   psum_ring_fifo #(
      .width (bw_psum * col),
      .depth (depth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (bus.peer_vld),
      .din_i     (bus.peer_data),
      .pop_i     (bus.norm_rd),
      .dout_o    (bus.sum_in),
      .push_ok_o (push_ok),
      .pop_ok_o  (pop_ok),
      .ovf_o     (bus.ovf),
      .udf_o     (bus.udf)
   );

   // Frame accounting: only accepted words count, so a dropped word shifts
   // the framing until the next reset.
   assign wr_wrap = push_ok && (wr_cnt_q == LAST);
   assign rd_wrap = pop_ok  && (rd_cnt_q == LAST);

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      frames_d = frames_q;
      if (push_ok) wr_cnt_d = wr_wrap ? '0 : wr_cnt_q + 1'b1;
      if (pop_ok)  rd_cnt_d = rd_wrap ? '0 : rd_cnt_q + 1'b1;
      case ({wr_wrap, rd_wrap})
         2'b10:   frames_d = frames_q + 1'b1;
         2'b01:   frames_d = (frames_q != 2'd0) ? frames_q - 1'b1 : frames_q;
         default: frames_d = frames_q;   // both or neither: net zero
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         frames_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         frames_q <= frames_d;
      end
   end

   // Receive FSM. IDLE looks at the registered frame count, which gives the
   // two-edge latency from the last push to fifo_in_ready. DRAIN looks at the
   // next-state count so a frame collected during the drain is announced on
   // the very edge that finishes the previous one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (frames_q != 2'd0) begin
                  state_q <= HOLD;
                  ready_q <= 1'b1;
               end
            end
            HOLD: begin
               if (pop_ok) begin
                  state_q <= DRAIN;
                  ready_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (rd_wrap) begin
                  if (frames_d != 2'd0) begin
                     state_q <= HOLD;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     ready_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_in_ready = ready_q;

endmodule

// File: doc/psum_xchg_rx.md
# psum_xchg_rx

Receive end of the inter-core partial-sum exchange. It captures the frame of `total_cycle` psum vectors that the peer core streams out while its `fifo_ext_rd` is high. It raises `fifo_in_ready` to the local controller once a complete frame is buffered, then drains the frame into the local core's `sum_in` one word per cycle while the local controller's `div` is high. It sits between the peer core's `sum_out`, the local core's `sum_in` and the local controller's WAIT/NORM handshake.

## Interface
- `bw`, 8: activation width
- `bw_psum`, 2*bw+4: psum element width
- `col`, 8: psum elements per word
- `total_cycle`, 8: words per frame
- `depth`, 16: buffer words; must equal 2*`total_cycle`, power of two
- `clk` in 1: single clock; all state updates on posedge
- `reset` in 1: synchronous, active-high
- `peer_vld` in 1: peer controller's `fifo_ext_rd`; one word per cycle while high
- `peer_data` in bw_psum*col: peer core `sum_out`, sampled when `peer_vld`=1
- `norm_rd` in 1: local controller `div`; pops one word per cycle
- `sum_in` out bw_psum*col: head word (show-ahead) to local core; 0 when empty
- `fifo_in_ready` out 1: a complete frame is at head and not yet partially drained
- `ovf` out 1: sticky, push attempted while full
- `udf` out 1: sticky, pop attempted while empty

## Operation
- Ring buffer of `depth` words with `wr_ptr`, `rd_ptr` (log2 `depth` bits, wrap modulo `depth`) and `count` (0..`depth`).
- Push: `peer_vld` and not full writes `peer_data` at `wr_ptr`, then advances the pointer.
  - `peer_vld` while full drops the word and sets `ovf`; the pointer does not move.
- Pop: `norm_rd` and not empty advances `rd_ptr`.
  - `norm_rd` while empty sets `udf`; no pointer change.
- Simultaneous push and pop are both honoured; `count` is unchanged.
- Frame accounting:
  - `wr_cnt` counts accepted pushes 0..`total_cycle`-1. When it wraps, `frames` (0..2) increments.
  - `rd_cnt` counts pops 0..`total_cycle`-1. When it wraps, `frames` decrements.
  - Both events in one cycle leave `frames` unchanged.
- Receive FSM:
  - IDLE: go to HOLD when `frames`>0.
  - HOLD: `fifo_in_ready`=1. The first accepted pop goes to DRAIN.
  - DRAIN: `fifo_in_ready`=0. The pop that wraps `rd_cnt` goes to HOLD if `frames` after update is >0, else to IDLE.
- `fifo_in_ready` is a registered FSM output (state==HOLD).
- A new peer frame may be collected while the previous frame drains; there are no ordering stalls.
- Dropped words still count nothing: `wr_cnt` counts only accepted words, so an overflow corrupts the framing. This is recoverable only by reset.
- Pass-through: `sum_in` = `mem[rd_ptr]` when `count`>0, else 0. Data is unmodified; there is no arithmetic.

## Timing
- Reset: on the posedge with `reset`=1 the following clear. Memory contents are don't-care.
  - Pointers, `count`, `wr_cnt`, `rd_cnt`, `frames`: 0
  - FSM: IDLE
  - `fifo_in_ready`, `ovf`, `udf`: 0
  - `sum_in`: 0
- Reset mid-frame or mid-drain discards all buffered data. Inputs are ignored during reset.
- Push to `sum_in` visibility, when the buffer was empty: 1 cycle, since `sum_in` follows the posedge that wrote the word.
- Last push of a frame to `fifo_in_ready`=1: 2 posedges (`frames` updates, then the FSM registers HOLD).
- First pop to `fifo_in_ready`=0: the same posedge.
- `sum_in` advances on each posedge where a pop is accepted. The local core samples the current head in the cycle `norm_rd` is high.
- Controller handshake signals change on negedge and are sampled on posedge; no input synchronizer is needed.

## Structure
- Shared package `psum_xchg_pkg`:
  - constants `BW_PSUM_DEF`, `COL_DEF`, `TOTAL_CYCLE_DEF`
  - FSM enum {IDLE, HOLD, DRAIN}
  - `ptr_t` width function
- One sub-module, `psum_ring_fifo`: storage, pointers, `count`, full/empty, `ovf`/`udf`, show-ahead read.
- Frame counters and the FSM stay in `psum_xchg_rx`.

## Test plan
- Reset, then push 8 words 0x1..0x8 on consecutive cycles:
  - `fifo_in_ready` rises exactly 2 posedges after the 8th push.
  - `sum_in`=0x1.
- `norm_rd` for 8 cycles:
  - `sum_in` steps 0x1..0x8.
  - `fifo_in_ready` drops on the first pop.
  - FSM returns to IDLE, `sum_in`=0 afterwards, `udf`=0.
- Push frame A (8 words), start draining it, and push frame B concurrently:
  - After A's 8th pop, FSM goes straight to HOLD with `fifo_in_ready`=1.
  - B drains in order.
  - Pointers wrap cleanly at 16.
- Push 17 words without popping:
  - `ovf`=1 after the 17th.
  - `frames`=2; the dropped word is absent.
  - `count`=16.
- `norm_rd` with the buffer empty: `udf`=1, `sum_in`=0, pointers unchanged.
- Assert `reset` after 5 pushes, then push a full 8-word frame:
  - `fifo_in_ready` asserts only after those 8 new words.
  - `sum_in` equals the first post-reset word.
